fetch_decode_queue: RTL



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_decode_queue.sv | 89 ++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants used by the fetch/decode queue.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned XLEN   = 32;

    // ADDI x0,x0,0 -- presented to decode whenever nothing is queued
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_decode_queue.sv
// First-word-fall-through {PC, instruction} queue between fetch and decode.
// Flush discards every queued entry on a branch/jump redirect.
module fetch_decode_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst_code,
    input  logic [XLEN-1:0]   in_pc,
    output logic              in_ready,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst_code,
    output logic [XLEN-1:0]   out_pc,
    input  logic              out_ready,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    // Handshake flags and head-of-queue presentation
    always_comb begin
        in_ready      = (count_q != FULL_CNT);
        out_valid     = (count_q != '0);
        push          = in_valid & in_ready;
        pop           = out_valid & out_ready;
        count         = count_q;
        out_inst_code = NOP_INST;
        out_pc        = '0;
        if (out_valid) begin
            out_inst_code = mem_q[rd_ptr_q].inst;
            out_pc        = mem_q[rd_ptr_q].pc;
        end
    end

    // Next-state: flush beats push/pop; reset is applied in the register block
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: in_pc, inst: in_inst_code};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage contents are not reset (don't-care when empty)
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : fetch_decode_queue
